// File: rtl/sensor_command_controller_if.sv
// Bundle of the request, DHT11-reader, UART-transmitter and status signals
// seen by sensor_command_controller; master is the controller side.
interface sensor_command_controller_if;
    logic       rx_done;
    logic [7:0] rx_cmd;
    logic [7:0] rx_addr;

    logic       sensor_start;
    logic [4:0] sensor_addr;
    logic       sensor_done;
    logic       sensor_error;
    logic [7:0] sensor_temp;
    logic [7:0] sensor_hum;

    logic       tx_start;
    logic [7:0] tx_byte0;
    logic [7:0] tx_byte1;
    logic       tx_done;

    logic       busy;
    logic       overrun;
    logic [1:0] cont_active;

    modport master (
        input  rx_done, rx_cmd, rx_addr,
        input  sensor_done, sensor_error, sensor_temp, sensor_hum,
        input  tx_done,
        output sensor_start, sensor_addr, tx_start, tx_byte0, tx_byte1,
        output busy, overrun, cont_active
    );

    modport slave (
        output rx_done, rx_cmd, rx_addr,
        output sensor_done, sensor_error, sensor_temp, sensor_hum,
        output tx_done,
        input  sensor_start, sensor_addr, tx_start, tx_byte0, tx_byte1,
        input  busy, overrun, cont_active
    );
endinterface

// File: rtl/sensor_command_controller.sv
// Decodes 2-byte requests, runs a DHT11 read when needed and hands a 2-byte
// response to the UART. Optional periodic re-reads: define CONTINUOUS_MODE_EN.
module sensor_command_controller #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CONT_PERIOD    = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    sensor_command_controller_if.master bus
);
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    if (TIMEOUT_CYCLES < 1 || CONT_PERIOD < 1) begin : gBadParams
        $error("sensor_command_controller: TIMEOUT_CYCLES and CONT_PERIOD must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE, DECODE, START_SENSOR, WAIT_SENSOR, LOAD_TX, WAIT_TX
    } stateType;

    stateType        stateReg, stateNext;
    logic [7:0]      curCmdReg, curCmdNext;
    logic [7:0]      curAddrReg, curAddrNext;
    logic            bufValidReg, bufValidNext;
    logic [7:0]      bufCmdReg, bufCmdNext;
    logic [7:0]      bufAddrReg, bufAddrNext;
    logic            overrunReg, overrunNext;
    logic [4:0]      sensorAddrReg, sensorAddrNext;
    logic [7:0]      txByte0Reg, txByte0Next;
    logic [7:0]      txByte1Reg, txByte1Next;
    logic [TO_W-1:0] timeoutCntReg, timeoutCntNext;
    logic            sensorCmd;
    logic            addrOk;

`ifdef CONTINUOUS_MODE_EN
    localparam int CP_W = (CONT_PERIOD > 1) ? $clog2(CONT_PERIOD) : 1;

    logic [1:0]      contActiveReg, contActiveNext;
    logic [CP_W-1:0] periodCntReg, periodCntNext;
    logic            altReg, altNext;
    logic            selHum;
    logic            periodDue;

    assign sensorCmd = (curCmdReg <= 8'h04);
    // Humidity is chosen when it is the only one enabled, or on alternate turns.
    assign selHum    = contActiveReg[1] & (~contActiveReg[0] | altReg);
    assign periodDue = (contActiveReg != 2'b00) &&
                       (periodCntReg == CP_W'(CONT_PERIOD - 1));
    assign bus.cont_active = contActiveReg;
`else
    assign sensorCmd = (curCmdReg <= 8'h02);
    assign bus.cont_active = 2'b00;
`endif

    assign addrOk           = (curAddrReg <= 8'h1F);
    assign bus.sensor_start = (stateReg == START_SENSOR);
    assign bus.tx_start     = (stateReg == LOAD_TX);
    assign bus.busy         = (stateReg != IDLE);
    assign bus.overrun      = overrunReg;
    assign bus.sensor_addr  = sensorAddrReg;
    assign bus.tx_byte0     = txByte0Reg;
    assign bus.tx_byte1     = txByte1Reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg      <= IDLE;
            curCmdReg     <= '0;
            curAddrReg    <= '0;
            bufValidReg   <= 1'b0;
            bufCmdReg     <= '0;
            bufAddrReg    <= '0;
            overrunReg    <= 1'b0;
            sensorAddrReg <= '0;
            txByte0Reg    <= '0;
            txByte1Reg    <= '0;
            timeoutCntReg <= '0;
`ifdef CONTINUOUS_MODE_EN
            contActiveReg <= '0;
            periodCntReg  <= '0;
            altReg        <= 1'b0;
`endif
        end else begin
            stateReg      <= stateNext;
            curCmdReg     <= curCmdNext;
            curAddrReg    <= curAddrNext;
            bufValidReg   <= bufValidNext;
            bufCmdReg     <= bufCmdNext;
            bufAddrReg    <= bufAddrNext;
            overrunReg    <= overrunNext;
            sensorAddrReg <= sensorAddrNext;
            txByte0Reg    <= txByte0Next;
            txByte1Reg    <= txByte1Next;
            timeoutCntReg <= timeoutCntNext;
`ifdef CONTINUOUS_MODE_EN
            contActiveReg <= contActiveNext;
            periodCntReg  <= periodCntNext;
            altReg        <= altNext;
`endif
        end
    end

    always_comb begin
        stateNext      = stateReg;
        curCmdNext     = curCmdReg;
        curAddrNext    = curAddrReg;
        bufValidNext   = bufValidReg;
        bufCmdNext     = bufCmdReg;
        bufAddrNext    = bufAddrReg;
        overrunNext    = overrunReg;
        sensorAddrNext = sensorAddrReg;
        txByte0Next    = txByte0Reg;
        txByte1Next    = txByte1Reg;
        timeoutCntNext = '0;
`ifdef CONTINUOUS_MODE_EN
        contActiveNext = contActiveReg;
        periodCntNext  = '0;
        altNext        = altReg;
`endif

        if (bus.rx_done && stateReg != IDLE) begin
            if (bufValidReg) begin
                overrunNext = 1'b1;
            end else begin
                bufValidNext = 1'b1;
                bufCmdNext   = bus.rx_cmd;
                bufAddrNext  = bus.rx_addr;
            end
        end

        case (stateReg)
            IDLE: begin
                // The buffered request is older, so it is served first and a
                // simultaneous new one takes its place in the buffer.
                if (bufValidReg) begin
                    curCmdNext   = bufCmdReg;
                    curAddrNext  = bufAddrReg;
                    bufValidNext = bus.rx_done;
                    if (bus.rx_done) begin
                        bufCmdNext  = bus.rx_cmd;
                        bufAddrNext = bus.rx_addr;
                    end
                    stateNext = DECODE;
                end else if (bus.rx_done) begin
                    curCmdNext  = bus.rx_cmd;
                    curAddrNext = bus.rx_addr;
                    stateNext   = DECODE;
                end
`ifdef CONTINUOUS_MODE_EN
                else if (periodDue) begin
                    curCmdNext  = selHum ? 8'h02 : 8'h01;
                    curAddrNext = {3'b000, sensorAddrReg};
                    altNext     = ~selHum;
                    stateNext   = DECODE;
                end else if (contActiveReg != 2'b00) begin
                    periodCntNext = periodCntReg + CP_W'(1);
                end
`endif
            end

            DECODE: begin
                if (sensorCmd && addrOk) begin
                    sensorAddrNext = curAddrReg[4:0];
                    stateNext      = START_SENSOR;
`ifdef CONTINUOUS_MODE_EN
                    if (curCmdReg == 8'h03) contActiveNext[0] = 1'b1;
                    if (curCmdReg == 8'h04) contActiveNext[1] = 1'b1;
`endif
                end else begin
                    stateNext   = LOAD_TX;
                    txByte1Next = 8'h00;
                    if (sensorCmd) begin
                        txByte0Next = 8'hEF;
                    end
`ifdef CONTINUOUS_MODE_EN
                    else if (curCmdReg == 8'h05) begin
                        txByte0Next       = 8'h0A;
                        contActiveNext[0] = 1'b0;
                    end else if (curCmdReg == 8'h06) begin
                        txByte0Next       = 8'h0B;
                        contActiveNext[1] = 1'b0;
                    end
`endif
                    else begin
                        txByte0Next = 8'hCF;
                    end
                end
            end

            START_SENSOR: stateNext = WAIT_SENSOR;

            WAIT_SENSOR: begin
                // sensor_done is tested first so it wins over a same-cycle timeout.
                if (bus.sensor_done) begin
                    stateNext   = LOAD_TX;
                    txByte1Next = 8'h00;
                    if (bus.sensor_error) begin
                        txByte0Next = 8'h1F;
                    end else if (curCmdReg == 8'h00) begin
                        txByte0Next = 8'h07;
                    end else if (curCmdReg == 8'h01 || curCmdReg == 8'h03) begin
                        txByte0Next = 8'h09;
                        txByte1Next = bus.sensor_temp;
                    end else begin
                        txByte0Next = 8'h08;
                        txByte1Next = bus.sensor_hum;
                    end
                end else if (timeoutCntReg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    stateNext   = LOAD_TX;
                    txByte0Next = 8'h1F;
                    txByte1Next = 8'h00;
                end else begin
                    timeoutCntNext = timeoutCntReg + TO_W'(1);
                end
            end

            LOAD_TX: stateNext = WAIT_TX;

            WAIT_TX: begin
                if (bus.tx_done) stateNext = IDLE;
            end

            default: stateNext = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sensor_command_controller.sv
// Self-checking bench for sensor_command_controller: directed table, random
// requests against a rule-level reference, and multi-cycle corner sequences.
module tb_sensor_command_controller;
    localparam int TO = 100;
    localparam int CP = 200;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sensor_command_controller_if bus();

    sensor_command_controller #(
        .TIMEOUT_CYCLES(TO),
        .CONT_PERIOD(CP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        int         lat;       // WAIT_SENSOR cycles before sensor_done; -1 = never
        logic       err;
        logic [7:0] temp;
        logic [7:0] hum;
        logic [7:0] exp0;
        logic [7:0] exp1;
        logic       expSensor;
    } vecRec;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] outWord();
        return 32'({bus.sensor_start, bus.tx_start, bus.busy, bus.overrun, bus.cont_active,
                    bus.tx_byte0, bus.tx_byte1, bus.sensor_addr});
    endfunction

    // Response rules: {sensor accessed, byte0, byte1}
    function automatic logic [16:0] refModel(input logic [7:0] cmd, input logic [7:0] addr,
                                             input logic timedOut, input logic err,
                                             input logic [7:0] temp, input logic [7:0] hum);
        logic readCmd;
        readCmd = (cmd <= 8'h02);
`ifdef CONTINUOUS_MODE_EN
        if (cmd == 8'h03 || cmd == 8'h04) readCmd = 1'b1;
`endif
        if (readCmd && addr > 8'h1F) return {1'b0, 8'hEF, 8'h00};
        if (readCmd) begin
            if (timedOut || err) return {1'b1, 8'h1F, 8'h00};
            case (cmd)
                8'h00:        return {1'b1, 8'h07, 8'h00};
                8'h01, 8'h03: return {1'b1, 8'h09, temp};
                default:      return {1'b1, 8'h08, hum};
            endcase
        end
`ifdef CONTINUOUS_MODE_EN
        if (cmd == 8'h05) return {1'b0, 8'h0A, 8'h00};
        if (cmd == 8'h06) return {1'b0, 8'h0B, 8'h00};
`endif
        return {1'b0, 8'hCF, 8'h00};
    endfunction

    task automatic pulseRx(input logic [7:0] cmd, input logic [7:0] addr);
        bus.rx_cmd  = cmd;
        bus.rx_addr = addr;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
    endtask

    task automatic runVector(input vecRec v);
        int cnt;
        int extra;
        int bad;
        pulseRx(v.cmd, v.addr);                       // cycle N+1: DECODE
        check("busy_decode", 32'(bus.busy), 32'd1);
        tick();                                       // cycle N+2
        check("sensor_start_n2", 32'(bus.sensor_start), 32'(v.expSensor));
        check("tx_start_n2", 32'(bus.tx_start), 32'(!v.expSensor));
        if (v.expSensor) begin
            check("sensor_addr", 32'(bus.sensor_addr), 32'(v.addr[4:0]));
            tick();
            extra = 0;
            cnt = 0;
            if (v.lat >= 0) begin
                repeat (v.lat) begin
                    if (bus.tx_start || bus.sensor_start) extra++;
                    tick();
                end
                bus.sensor_done  = 1'b1;
                bus.sensor_error = v.err;
                bus.sensor_temp  = v.temp;
                bus.sensor_hum   = v.hum;
                tick();
                bus.sensor_done  = 1'b0;
                bus.sensor_error = 1'b0;
                check("wait_sensor_quiet", 32'(extra), 32'd0);
            end else begin
                while (bus.tx_start == 1'b0 && cnt < TO + 10) begin
                    cnt++;
                    tick();
                end
                check("timeout_len", 32'(cnt), 32'(TO));
            end
            check("tx_start_after_sensor", 32'(bus.tx_start), 32'd1);
        end
        check("tx_bytes", 32'({bus.tx_byte0, bus.tx_byte1}), 32'({v.exp0, v.exp1}));
        // A stray sensor_done outside WAIT_SENSOR must not disturb the held bytes.
        bad = 0;
        bus.sensor_done  = 1'b1;
        bus.sensor_error = 1'b1;
        bus.sensor_temp  = ~v.temp;
        repeat (3) begin
            tick();
            bus.sensor_done  = 1'b0;
            bus.sensor_error = 1'b0;
            if (bus.tx_start || !bus.busy || bus.tx_byte0 !== v.exp0 || bus.tx_byte1 !== v.exp1)
                bad++;
        end
        check("wait_tx_hold", 32'(bad), 32'd0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("busy_after_tx_done", 32'(bus.busy), 32'd0);
        $display("txn cmd=%02h addr=%02h lat=%0d err=%0d -> %02h %02h",
                 v.cmd, v.addr, v.lat, v.err, bus.tx_byte0, bus.tx_byte1);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecRec tbl[10];
        vecRec v;
        int extra;
        int r;

        tbl[0] = '{8'h01, 8'h03, 2,      1'b0, 8'h19, 8'h00, 8'h09, 8'h19, 1'b1};
        tbl[1] = '{8'h7E, 8'h00, 0,      1'b0, 8'h00, 8'h00, 8'hCF, 8'h00, 1'b0};
        tbl[2] = '{8'h02, 8'h05, -1,     1'b0, 8'h00, 8'h00, 8'h1F, 8'h00, 1'b1};
        tbl[3] = '{8'h00, 8'h01, 1,      1'b0, 8'h00, 8'h00, 8'h07, 8'h00, 1'b1};
        tbl[4] = '{8'h00, 8'h01, 0,      1'b1, 8'h00, 8'h00, 8'h1F, 8'h00, 1'b1};
        tbl[5] = '{8'h02, 8'h1F, 0,      1'b0, 8'h00, 8'h37, 8'h08, 8'h37, 1'b1};
        tbl[6] = '{8'h01, 8'h20, 0,      1'b0, 8'h00, 8'h00, 8'hEF, 8'h00, 1'b0};
        tbl[7] = '{8'h01, 8'h04, TO - 1, 1'b0, 8'h2A, 8'h00, 8'h09, 8'h2A, 1'b1};
`ifdef CONTINUOUS_MODE_EN
        tbl[8] = '{8'h05, 8'h00, 0,      1'b0, 8'h00, 8'h00, 8'h0A, 8'h00, 1'b0};
`else
        tbl[8] = '{8'h05, 8'h00, 0,      1'b0, 8'h00, 8'h00, 8'hCF, 8'h00, 1'b0};
`endif
        tbl[9] = '{8'h01, 8'h02, 3,      1'b1, 8'h55, 8'h66, 8'h1F, 8'h00, 1'b1};

        reset = 1'b1;
        bus.rx_done = 1'b0;      bus.rx_cmd = '0;       bus.rx_addr = '0;
        bus.sensor_done = 1'b0;  bus.sensor_error = 1'b0;
        bus.sensor_temp = '0;    bus.sensor_hum = '0;   bus.tx_done = 1'b0;
        repeat (3) tick();
        check("reset_outputs", outWord(), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_after_reset", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 10; i++) runVector(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      v.cmd = 8'(r);
            else if (r == 7) v.cmd = 8'h7E;
            else             v.cmd = 8'($urandom);
`ifdef CONTINUOUS_MODE_EN
            if (v.cmd == 8'h03 || v.cmd == 8'h04) v.cmd = 8'h01;
`endif
            v.addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            v.lat  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
            v.err  = ($urandom_range(0, 3) == 0);
            v.temp = 8'($urandom);
            v.hum  = 8'($urandom);
            {v.expSensor, v.exp0, v.exp1} = refModel(v.cmd, v.addr, v.lat < 0, v.err, v.temp, v.hum);
            runVector(v);
        end

        // Overrun: one request running, two more arrive during WAIT_SENSOR.
        check("ovr_clear_before", 32'(bus.overrun), 32'd0);
        pulseRx(8'h01, 8'h03);
        tick();
        check("ovr_first_start", 32'(bus.sensor_start), 32'd1);
        tick();
        pulseRx(8'h02, 8'h06);
        check("ovr_after_second", 32'(bus.overrun), 32'd0);
        pulseRx(8'h7E, 8'h00);
        check("ovr_after_third", 32'(bus.overrun), 32'd1);
        bus.sensor_temp = 8'h11;
        bus.sensor_done = 1'b1;
        tick();
        bus.sensor_done = 1'b0;
        check("ovr_first_resp", 32'({bus.tx_start, bus.tx_byte0, bus.tx_byte1}), 32'({1'b1, 8'h09, 8'h11}));
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("ovr_idle_gap", 32'(bus.busy), 32'd0);
        tick();
        tick();
        check("ovr_second_start", 32'({bus.sensor_start, bus.sensor_addr}), 32'({1'b1, 5'h06}));
        tick();
        bus.sensor_hum  = 8'h44;
        bus.sensor_done = 1'b1;
        tick();
        bus.sensor_done = 1'b0;
        check("ovr_second_resp", 32'({bus.tx_start, bus.tx_byte0, bus.tx_byte1}), 32'({1'b1, 8'h08, 8'h44}));
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        extra = 0;
        repeat (20) begin
            if (bus.busy || bus.tx_start || bus.sensor_start) extra++;
            tick();
        end
        check("ovr_third_dropped", 32'(extra), 32'd0);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        $display("txn overrun sequence done, overrun=%0d", bus.overrun);

        // Reset while waiting for the UART; a late tx_done must be ignored.
        pulseRx(8'h01, 8'h09);
        tick();
        tick();
        bus.sensor_temp = 8'h5A;
        bus.sensor_done = 1'b1;
        tick();
        bus.sensor_done = 1'b0;
        tick();
        check("rst_pre_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wait_tx_outputs", outWord(), 32'd0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        extra = 0;
        repeat (5) begin
            if (bus.busy || bus.tx_start || bus.sensor_start) extra++;
            tick();
        end
        check("rst_tx_done_ignored", 32'(extra), 32'd0);
        $display("txn reset in WAIT_TX done");

`ifdef CONTINUOUS_MODE_EN
        runVector('{8'h03, 8'h07, 1, 1'b0, 8'h21, 8'h00, 8'h09, 8'h21, 1'b1});
        check("cont_set", 32'(bus.cont_active), 32'd1);
        for (int k = 0; k < 2; k++) begin
            int cnt;
            cnt = 0;
            while (!bus.busy && cnt < CP + 50) begin
                cnt++;
                tick();
            end
            check("cont_period_window", 32'(cnt >= CP - 5 && cnt <= CP + 5), 32'd1);
            tick();
            check("cont_start", 32'({bus.sensor_start, bus.sensor_addr}), 32'({1'b1, 5'h07}));
            tick();
            bus.sensor_temp = 8'(8'h30 + k);
            bus.sensor_done = 1'b1;
            tick();
            bus.sensor_done = 1'b0;
            check("cont_resp", 32'({bus.tx_start, bus.tx_byte0, bus.tx_byte1}),
                  32'({1'b1, 8'h09, 8'(8'h30 + k)}));
            tick();
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
            $display("txn cont self-read %0d after %0d idle cycles", k, cnt);
        end
        runVector('{8'h05, 8'h07, 0, 1'b0, 8'h00, 8'h00, 8'h0A, 8'h00, 1'b0});
        check("cont_cleared", 32'(bus.cont_active), 32'd0);
        extra = 0;
        repeat (2 * CP + 20) begin
            if (bus.busy) extra++;
            tick();
        end
        check("cont_quiet", 32'(extra), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
